// File: rtl/cim_readout_if.sv
// rtl/cim_readout_if.sv - valid/ready word stream carrying a cell value, its index and a last flag
interface cim_readout_if #(
    parameter int N_GROUP    = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_WIDTH = $clog2(N_GROUP) + 1;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [IDX_WIDTH-1:0]  m_idx;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_idx,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_idx,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/cim_readout.sv
// rtl/cim_readout.sv - snapshots a cell-group accumulator vector and drains it word by word
module cim_readout #(
    parameter int N_GROUP    = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N_GROUP*DATA_WIDTH-1:0] data_i,
    output logic                          busy,
    output logic                          done,
    cim_readout_if.master                 m
);
    localparam int IDX_WIDTH = $clog2(N_GROUP) + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_GROUP - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                state_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  idx_d;
    logic                  valid_q;
    logic                  busy_q;
    logic                  last_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] shadow_q [N_GROUP];
    logic [DATA_WIDTH-1:0] data_mux;

    assign idx_d = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_GROUP; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_GROUP; i++) begin
                            shadow_q[i] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (LAST_IDX == '0);
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // start is deliberately not looked at here, so requests during a drain are dropped
                    if (m.m_ready) begin
                        if (last_q) begin
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q  <= idx_d;
                            last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read mux is driven only by registered idx, keeping m_ready out of the output cone
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < N_GROUP; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                data_mux = shadow_q[i];
            end
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_data  = data_mux;
    assign m.m_idx   = idx_q;
    assign m.m_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: doc/cim_readout.md
# cim_readout

Drains the accumulator vector of a CiM cell group. On a start pulse it snapshots all `N_GROUP` cell values into shadow registers. It then streams them out one word per handshake on a valid/ready master port, in index order 0..N_GROUP-1, tagging each word with its cell index and a last flag. It sits between the cell-group parallel `data_o` bus and the host/DMA result path, so accumulation can continue while results are drained.

## Interface
- `N_GROUP`, 12, number of cells read per drain; must be ≥1.
- `DATA_WIDTH`, 32, width of each cell word.
- `IDX_WIDTH` (local), `$clog2(N_GROUP)+1`, index width; same rule as the cell-group counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  drain request; sampled only in IDLE.
- `data_i`  in  N_GROUP×DATA_WIDTH  packed cell values; element i = cell i.
- `busy`  out  1  high while a drain is in progress.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts word.
- `m_data`  out  DATA_WIDTH  snapshot word for cell `m_idx`.
- `m_idx`  out  IDX_WIDTH  cell index of current word.
- `m_last`  out  1  high with the word for index N_GROUP-1.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, SEND.
- IDLE:
  - `busy`=0, `m_valid`=0.
  - `start`=1 → on that clock edge, copy all of `data_i` into the shadow array, set idx=0, and go to SEND.
- SEND:
  - `busy`=1, `m_valid`=1.
  - `m_data`=shadow[idx], `m_idx`=idx, `m_last`=(idx==N_GROUP-1).
  - A transfer occurs on a cycle where `m_valid`&&`m_ready`.
  - Transfer with `m_last`=0 → idx+1.
  - Transfer with `m_last`=1 → go to IDLE, idx=0, and register `done`=1 for the next cycle.
- Stall: while `m_valid`&&!`m_ready`, hold `m_data`, `m_idx` and `m_last` stable. `m_valid` never drops before its transfer.
- `start` in SEND, including the cycle of the final transfer, is ignored and not queued.
- Snapshot isolation: changes on `data_i` after the capture edge never affect the words being sent.
- idx never exceeds N_GROUP-1. No wrap occurs inside a drain.
- N_GROUP=1: a single word is sent with `m_idx`=0 and `m_last`=1.
- No combinational path from `m_ready` to `m_valid`, `m_data`, `m_idx` or `m_last`. All of these derive from registered state.
- Words are sent unmodified. No arithmetic on the data path.

## Timing
- Reset values:
  - State=IDLE, idx=0.
  - `busy`=0, `m_valid`=0, `m_last`=0, `done`=0, `m_idx`=0.
  - `m_data`=0 (shadow array cleared).
- Reset mid-drain takes effect at the next edge:
  - Return to IDLE and drop `m_valid` at once.
  - Remaining words are discarded. No `done` pulse.
- `start` sampled high at edge t → `m_valid`=1 with word 0 in cycle t+1.
- With `m_ready` held high:
  - Words 0..N_GROUP-1 appear in cycles t+1..t+N_GROUP.
  - `done`=1 and `busy`=0 in cycle t+N_GROUP+1.
- Earliest next accepted `start` is at the edge ending cycle t+N_GROUP+1. Minimum drain-to-drain period is N_GROUP+1 cycles.
- Each stall cycle adds exactly one cycle to the drain.

## Test plan
- Reset, then idle 5 cycles with `m_ready`=1 → all outputs 0, no `m_valid`, no `done`.
- N_GROUP=12, `data_i[i]`=0x100+i, `start` pulse, `m_ready`=1:
  - 12 words 0x100..0x10B with `m_idx` 0..11, consecutive cycles.
  - `m_last` only on idx 11.
  - `done` one cycle later; `busy` high for exactly 12 cycles.
- Backpressure: `m_ready` toggling 1,0,0,1,… → every word appears exactly once, in order, held stable during low-ready cycles. Drain length = 12 + stall count.
- Snapshot/ignore:
  - After `start`, change all `data_i` to 0xFFFF_FFFF → stream still 0x100..0x10B.
  - Extra `start` pulses in SEND, including the final-transfer cycle → no second drain.
- Reset mid-drain after word 5 is accepted → `m_valid` low next cycle, no `done`. A following `start` sends from idx 0.
- N_GROUP=1, `data_i`=0xDEAD_BEEF → one word with `m_idx`=0 and `m_last`=1; `done` in cycle t+2.
